seven_segment_scan: RTL and testbench
=====================================

// Module: seven_segment_scan
// PURPOSE
//  Parametrised multiplexed seven-segment driver for the board display.
//  Successor to the fixed 32-bit hex driver: N digits, hex or decimal mode,
//  leading-zero blanking and decimal overflow indication.
//  Decimal uses an iterative double-dabble converter with a load/busy
//  handshake. Sits between the top-level number mux and the abcdefgh/digit pins.
// PARAMETERS
//  n_digits  8   number of digits scanned (>=2)
//  w         32  width of num; hex shows num[4*n_digits-1:0], zero-extended if w is smaller
// PORTS
//  clk       in   1         system clock
//  reset     in   1         synchronous, active-high
//  en        in   1         scan strobe; advances digit index by one
//  load      in   1         sample num/mode when busy==0
//  num       in   w         value to display
//  mode      in   1         0 = hex, 1 = unsigned decimal
//  blank_lz  in   1         1 = blank leading zero digits
//  dots      in   n_digits  dot request per digit, active-high
//  abcdefg   out  7         segments a=bit6..g=bit0, active-low, registered
//  dot       out  1         dot segment, active-low, registered
//  anodes    out  n_digits  digit enables, active-low one-hot, registered
//  busy      out  1         decimal conversion in progress
// BEHAVIOUR
//  Reset: index=0, display register=0 (all digits '0'), busy=0, overflow=0,
//   anodes=all 1, abcdefg=7'h7F, dot=1. Reset mid-conversion aborts conversion.
//  Scan: index increments on en, wraps n_digits-1 -> 0. Outputs are registered
//   every clk from the current index; latency 1 clk after index changes.
//   anodes[i]=0 iff index==i. dot=~dots[index]. dots is not sampled by load.
//  Hex load: load & !busy -> display register <= nibbles of num on the next clk.
//   busy stays 0.
//  Decimal load: load & !busy -> mode captured; busy=1 from the next clk for
//   exactly w clks. Per clk: add 3 to every BCD digit >=5, then shift one num
//   bit in (MSB first). A 1 shifted out of the top BCD digit sets overflow.
//   On the final clk, display register and overflow are updated atomically and
//   busy drops. The display holds its old value throughout conversion.
//  load while busy (including the final clk) is ignored. mode/num changes
//   while busy have no effect.
//  Overflow (num >= 10**n_digits): every digit shows '-' (7'b1111110).
//   Blanking does not apply. Cleared by the next successful load.
//  Blanking: when blank_lz=1, digits above the most significant nonzero digit
//   show 7'h7F. Digit 0 is never blanked. Dots are unaffected.
//  Segment codes (active-low): 0=0000001 1=1001111 2=0010010 3=0000110
//   4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000
//   b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
// TESTING
//  1 reset, then one en -> before en: anodes=8'hFF, abcdefg=7'h7F, dot=1,
//    busy=0; after en: anodes=8'hFE, abcdefg=7'b0000001.
//  2 hex load 32'h1234ABCD, 9 en -> anodes FE,FD,..,7F,FE; digits 0..7 show
//    D,C,b,A,4,3,2,1.
//  3 decimal load 12345678 -> busy=1 for exactly 32 clks; digit0 shows '8',
//    digit7 shows '1'. Old display is held until busy falls.
//  4 decimal with blank_lz=1: load 42 -> digits 7..2 = 7'h7F, digit1 '4',
//    digit0 '2'. Load 0 -> only digit0 lit, showing '0'.
//  5 decimal load 100000000 -> all 8 digits 7'b1111110. A later load of 5
//    clears overflow.
//  6 load asserted on clks 5 and 32 of a conversion is ignored. Reset on clk 10
//    of a second conversion -> busy=0, digits show '0', anodes=8'hFF.

Source files
------------

// File: rtl/seven_segment_scan.sv
// seven_segment_scan: multiplexed N-digit seven-segment driver with hex or decimal display,
// leading-zero blanking and decimal overflow indication.
module seven_segment_scan #(
    parameter int n_digits = 8,
    parameter int w = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                load,
    input  logic [w-1:0]        num,
    input  logic                mode,
    input  logic                blank_lz,
    input  logic [n_digits-1:0] dots,
    output logic [6:0]          abcdefg,
    output logic                dot,
    output logic [n_digits-1:0] anodes,
    output logic                busy
);
    localparam int dw = 4 * n_digits;
    localparam int iw = $clog2(n_digits);
    localparam int cw = $clog2(w + 1);
    localparam logic [iw-1:0] last_idx = iw'(n_digits - 1);
    localparam logic [15:0][6:0] seg_lut = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

    typedef enum logic {idle, conv} state_t;
    state_t state, state_next;

    logic [iw-1:0] idx;
    logic [dw-1:0] disp, bcd, bcd_adj, bcd_shift, num_ext;
    logic [w-1:0]  bin;
    logic [cw-1:0] cnt;
    logic          ovf, ovf_acc, carry, last_step, blank;
    logic [3:0]    digit;

    if (w >= dw) begin : g_trunc
        assign num_ext = num[dw-1:0];
    end else begin : g_extend
        assign num_ext = {{(dw - w){1'b0}}, num};
    end

    assign busy      = state == conv;
    assign last_step = cnt == cw'(1);
    assign digit     = disp[4*idx +: 4];
    // A digit is blank when it and everything above it is zero; digit 0 always shows.
    assign blank     = blank_lz && idx != '0 && (disp >> (4 * idx)) == '0;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < n_digits; i++)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        {carry, bcd_shift} = {bcd_adj, bin[w-1]};
        state_next = state == idle ? (load && mode ? conv : idle) : (last_step ? idle : conv);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= idle;
            idx     <= '0;
            disp    <= '0;
            ovf     <= 1'b0;
            ovf_acc <= 1'b0;
            cnt     <= '0;
            bcd     <= '0;
            bin     <= '0;
            anodes  <= '1;
            abcdefg <= 7'h7F;
            dot     <= 1'b1;
        end else begin
            state <= state_next;
            if (en)
                idx <= idx == last_idx ? '0 : idx + 1'b1;
            if (state == idle && load) begin
                if (mode) begin
                    cnt     <= cw'(w);
                    bin     <= num;
                    bcd     <= '0;
                    ovf_acc <= 1'b0;
                end else begin
                    disp <= num_ext;
                    ovf  <= 1'b0;
                end
            end else if (state == conv) begin
                cnt     <= cnt - 1'b1;
                bin     <= {bin[w-2:0], 1'b0};
                bcd     <= bcd_shift;
                ovf_acc <= ovf_acc | carry;
                // Display and overflow change together so no half-converted value is ever shown.
                if (last_step) begin
                    disp <= bcd_shift;
                    ovf  <= ovf_acc | carry;
                end
            end
            anodes  <= ~(n_digits'(1) << idx);
            abcdefg <= ovf ? 7'b1111110 : blank ? 7'h7F : seg_lut[digit];
            dot     <= ~dots[idx];
        end
    end
endmodule

// File: tb/tb_seven_segment_scan.sv
// tb_seven_segment_scan: scoreboard bench for the scanned seven-segment driver.
module tb_seven_segment_scan;
    logic        clk = 0, reset = 1, en = 0, load = 0, mode = 0, blank_lz = 0, dot, busy;
    logic [31:0] num = 0;
    logic [7:0]  dots = 0, anodes;
    logic [6:0]  abcdefg;

    int n_checks = 0, n_fail = 0, exp_idx = 0, busy_clks = 0;
    logic [31:0] model_disp = 0;
    logic        model_ovf = 0;
    logic [15:0] exp_q[$], obs_q[$];
    logic [15:0] e, o;

    seven_segment_scan #(.n_digits(8), .w(32)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .num(num), .mode(mode),
        .blank_lz(blank_lz), .dots(dots), .abcdefg(abcdefg), .dot(dot),
        .anodes(anodes), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'h0: return 7'b0000001; 4'h1: return 7'b1001111;
            4'h2: return 7'b0010010; 4'h3: return 7'b0000110;
            4'h4: return 7'b1001100; 4'h5: return 7'b0100100;
            4'h6: return 7'b0100000; 4'h7: return 7'b0001111;
            4'h8: return 7'b0000000; 4'h9: return 7'b0000100;
            4'hA: return 7'b0001000; 4'hB: return 7'b1100000;
            4'hC: return 7'b0110001; 4'hD: return 7'b1000010;
            4'hE: return 7'b0110000; default: return 7'b0111000;
        endcase
    endfunction

    function automatic logic [15:0] exp_out(input int i);
        logic [6:0] s;
        logic [7:0] an;
        an = 8'hFF;
        an[i] = 1'b0;
        if (model_ovf) s = 7'b1111110;
        else if (blank_lz && i != 0 && (model_disp >> (4 * i)) == 0) s = 7'h7F;
        else s = seg_of(model_disp[4*i +: 4]);
        return {an, s, ~dots[i]};
    endfunction

    function automatic void set_dec(input longint v);
        longint p = 1;
        model_ovf = v >= 64'd100000000;
        model_disp = 0;
        for (int k = 0; k < 8; k++) begin
            model_disp[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
        exp_idx = 0;
        model_disp = 0;
        model_ovf = 0;
    endtask

    task automatic scan(input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(exp_out(exp_idx));
            en = 1;
            tick();
            obs_q.push_back({anodes, abcdefg, dot});
            exp_idx = (exp_idx + 1) % 8;
        end
        en = 0;
    endtask

    task automatic hex_load(input logic [31:0] v);
        load = 1; mode = 0; num = v;
        tick();
        load = 0;
        model_disp = v;
        model_ovf = 0;
    endtask

    task automatic dec_load(input logic [31:0] v);
        load = 1; mode = 1; num = v;
        tick();
        load = 0;
        busy_clks = 0;
        while (busy === 1'b1 && busy_clks < 100) begin
            tick();
            busy_clks++;
        end
        set_dec(v);
    endtask

    task automatic test_reset();
        reset = 1;
        tick();
        tick();
        n_checks++; if (anodes !== 8'hFF) begin n_fail++; $display("FAIL reset_anodes: got %h want ff", anodes); end
        n_checks++; if (abcdefg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h want 7f", abcdefg); end
        n_checks++; if (dot !== 1'b1) begin n_fail++; $display("FAIL reset_dot: got %b want 1", dot); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 0;
        exp_idx = 0; model_disp = 0; model_ovf = 0;
        n_checks++; if (anodes !== 8'hFF) begin n_fail++; $display("FAIL pre_en_anodes: got %h want ff", anodes); end
        en = 1;
        tick();
        en = 0;
        n_checks++; if (anodes !== 8'hFE) begin n_fail++; $display("FAIL first_en_anodes: got %h want fe", anodes); end
        n_checks++; if (abcdefg !== 7'b0000001) begin n_fail++; $display("FAIL first_en_seg: got %b want 0000001", abcdefg); end
    endtask

    task automatic test_hex();
        do_reset();
        dots = 8'b1010_0101;
        blank_lz = 0;
        hex_load(32'h1234ABCD);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hex_busy: got %b want 0", busy); end
        scan(9);
        blank_lz = 1;
        hex_load(32'h0000_00A0);
        scan(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL hex_scan: got %h want %h", o, e); end
        end
        dots = 0;
    endtask

    task automatic test_decimal();
        do_reset();
        blank_lz = 0;
        hex_load(32'hFFFF_FFFF);
        load = 1; mode = 1; num = 32'd12345678;
        tick();
        load = 0;
        busy_clks = 0;
        while (busy === 1'b1 && busy_clks < 100) begin
            if (busy_clks < 8) begin exp_q.push_back(exp_out(exp_idx)); en = 1; end
            else en = 0;
            tick();
            busy_clks++;
            if (en) begin obs_q.push_back({anodes, abcdefg, dot}); exp_idx = (exp_idx + 1) % 8; end
        end
        en = 0;
        n_checks++; if (busy_clks !== 32) begin n_fail++; $display("FAIL dec_busy_len: got %0d want 32", busy_clks); end
        set_dec(12345678);
        scan(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL dec_scan: got %h want %h", o, e); end
        end
    endtask

    task automatic test_blanking();
        do_reset();
        blank_lz = 1;
        dec_load(42);
        scan(8);
        dec_load(0);
        scan(8);
        blank_lz = 0;
        dec_load(99999999);
        scan(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL blank_scan: got %h want %h", o, e); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        blank_lz = 1;
        dec_load(100000000);
        n_checks++; if (model_ovf !== 1'b1 || busy_clks !== 32) begin n_fail++; $display("FAIL ovf_busy_len: got %0d want 32", busy_clks); end
        scan(8);
        dec_load(5);
        scan(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL ovf_scan: got %h want %h", o, e); end
        end
        blank_lz = 0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        load = 1; mode = 1; num = 32'd1234;
        tick();
        busy_clks = 0;
        while (busy === 1'b1 && busy_clks < 100) begin
            load = busy_clks == 4 || busy_clks == 31;
            mode = busy_clks != 4;
            num = busy_clks == 4 ? 32'hDEAD_BEEF : 32'd99;
            tick();
            busy_clks++;
        end
        load = 0;
        n_checks++; if (busy_clks !== 32) begin n_fail++; $display("FAIL ignore_busy_len: got %0d want 32", busy_clks); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_final_load: got %b want 0", busy); end
        set_dec(1234);
        scan(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL ignore_scan: got %h want %h", o, e); end
        end
        load = 1; mode = 1; num = 32'd87654321;
        tick();
        load = 0;
        for (int k = 0; k < 9; k++) tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
        reset = 1;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_checks++; if (anodes !== 8'hFF) begin n_fail++; $display("FAIL abort_anodes: got %h want ff", anodes); end
        reset = 0;
        exp_idx = 0; model_disp = 0; model_ovf = 0;
        scan(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL abort_scan: got %h want %h", o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_hex();
        test_decimal();
        test_blanking();
        test_overflow();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
